// File: rtl/viterbi_pkg.sv
// rtl/viterbi_pkg.sv - shared constants and feeder state type for the K=3 convolutional chain
package viterbi_pkg;

  localparam int K             = 3;
  localparam int TAIL_BITS_DEF = K - 1;

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT, TAIL} feeder_state_t;

  // Counter width for a limit n, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_frame_feeder.sv
// rtl/conv_frame_feeder.sv - serialises parallel words MSB-first into the encoder, appending zero tail bits per frame
module conv_frame_feeder
  import viterbi_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int FRAME_WORDS = 4,
  parameter int TAIL_BITS   = TAIL_BITS_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_abort,
  output logic              o_ready,
  output logic              o_bit,
  output logic              o_en,
  output logic              o_sof,
  output logic              o_eof,
  output logic              o_tail,
  output logic              o_trunc
);

  localparam int BW = cnt_w(DATA_W);
  localparam int WW = cnt_w(FRAME_WORDS);
  localparam int TW = cnt_w(TAIL_BITS);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
  localparam logic [WW-1:0] WORD_LAST = WW'(FRAME_WORDS - 1);
  localparam logic [TW-1:0] TAIL_LAST = TW'(TAIL_BITS - 1);

  feeder_state_t     state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [WW-1:0]     word_cnt_q, word_cnt_d;
  logic [TW-1:0]     tail_cnt_q, tail_cnt_d;
  logic              abort_q, abort_d;
  logic              rdy_q;
  logic              bit_q, bit_d, en_q, en_d, sof_q, sof_d;
  logic              eof_q, eof_d, tail_q, tail_d, trunc_q, trunc_d;

  logic last_bit, last_word, last_tail, abort_req, hs, load, new_frame;

  assign last_bit  = (bit_cnt_q == BIT_LAST);
  assign last_word = (word_cnt_q == WORD_LAST);
  assign last_tail = (tail_cnt_q == TAIL_LAST);
  assign abort_req = i_abort && ((state_q == SHIFT) || (state_q == WAIT));

  // rdy_q keeps o_ready low through reset and for the first edge after release.
  assign o_ready = rdy_q && ((state_q == IDLE) || (state_q == WAIT) ||
                             ((state_q == SHIFT) && last_bit && !last_word) ||
                             ((state_q == TAIL) && last_tail));
  assign hs        = i_valid && o_ready;
  assign load      = hs && (state_d == SHIFT);
  assign new_frame = (state_q == IDLE) || (state_q == TAIL);

  assign o_bit   = bit_q;
  assign o_en    = en_q;
  assign o_sof   = sof_q;
  assign o_eof   = eof_q;
  assign o_tail  = tail_q;
  assign o_trunc = trunc_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      tail_cnt_q <= '0;
      abort_q    <= 1'b0;
      rdy_q      <= 1'b0;
      bit_q      <= 1'b0;
      en_q       <= 1'b0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      tail_q     <= 1'b0;
      trunc_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      tail_cnt_q <= tail_cnt_d;
      abort_q    <= abort_d;
      rdy_q      <= 1'b1;
      bit_q      <= bit_d;
      en_q       <= en_d;
      sof_q      <= sof_d;
      eof_q      <= eof_d;
      tail_q     <= tail_d;
      trunc_q    <= trunc_d;
    end
  end

  // Abort takes priority over a coincident handshake, so that word is dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (hs) state_d = SHIFT;
      SHIFT: begin
        if (abort_req)      state_d = TAIL;
        else if (last_bit) begin
          if (last_word)    state_d = TAIL;
          else if (hs)      state_d = SHIFT;
          else              state_d = WAIT;
        end
      end
      WAIT: begin
        if (abort_req)      state_d = TAIL;
        else if (hs)        state_d = SHIFT;
      end
      TAIL:  if (last_tail) state_d = hs ? SHIFT : IDLE;
      default:              state_d = IDLE;
    endcase
  end

  // Output registers carry the values for the state being entered.
  always_comb begin
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    tail_cnt_d = '0;
    abort_d    = abort_q;
    bit_d      = 1'b0;
    en_d       = 1'b0;
    sof_d      = 1'b0;
    eof_d      = 1'b0;
    tail_d     = 1'b0;
    trunc_d    = 1'b0;
    case (state_d)
      SHIFT: begin
        en_d    = 1'b1;
        abort_d = 1'b0;
        if (load) begin
          bit_d      = i_data[DATA_W-1];
          shreg_d    = {i_data[DATA_W-2:0], 1'b0};
          bit_cnt_d  = '0;
          sof_d      = new_frame;
          word_cnt_d = new_frame ? '0 : word_cnt_q + 1'b1;
        end else begin
          bit_d     = shreg_q[DATA_W-1];
          shreg_d   = {shreg_q[DATA_W-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      TAIL: begin
        en_d       = 1'b1;
        tail_d     = 1'b1;
        shreg_d    = '0;
        abort_d    = abort_q | abort_req;
        tail_cnt_d = (state_q == TAIL) ? tail_cnt_q + 1'b1 : '0;
        eof_d      = (tail_cnt_d == TAIL_LAST);
        trunc_d    = eof_d && abort_d;
      end
      IDLE: begin
        abort_d    = 1'b0;
        shreg_d    = '0;
        bit_cnt_d  = '0;
        word_cnt_d = '0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_conv_frame_feeder.sv
// tb/tb_conv_frame_feeder.sv - directed self-checking bench for conv_frame_feeder
module tb_conv_frame_feeder;

  logic clk = 1'b0, rst_n = 1'b1, valid = 1'b0, abort = 1'b0;
  logic [7:0] data = '0;
  logic ready, obit, en, sof, eof, tail, trunc;

  int checks = 0, errors = 0;
  int m_cyc = 0, m_en = 0, m_hs = 0, m_sof = 0, m_eof = 0, m_tail = 0;
  int m_rise = 0, m_gap = 0, m_gap_bad = 0;
  int m_sof_pos = 0, m_eof_pos = 0, m_hs_last = 0, m_rise_last = 0;
  logic m_eof_tail = 1'b0, m_eof_trunc = 1'b0, m_prev_en = 1'b0, m_open = 1'b0;
  logic [1:0]   m_enc  = '0;
  logic [127:0] m_bits = '0;
  int en0, hs0, sof0, eof0, rise0, gap0, gapb0, tail0;
  logic [33:0] exp34;
  logic [67:0] exp68;

  always #5 clk = ~clk;

  conv_frame_feeder dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (valid),
    .i_data  (data),
    .i_abort (abort),
    .o_ready (ready),
    .o_bit   (obit),
    .o_en    (en),
    .o_sof   (sof),
    .o_eof   (eof),
    .o_tail  (tail),
    .o_trunc (trunc)
  );

  // Output monitor with a K=3 encoder state model driven by o_bit/o_en.
  always @(negedge clk) begin
    m_cyc++;
    if (!rst_n) begin
      m_enc = '0; m_prev_en = 1'b0; m_open = 1'b0;
    end else begin
      if (valid && ready) begin m_hs++; m_hs_last = m_cyc; end
      if (en) begin
        m_en++;
        m_bits = {m_bits[126:0], obit};
        m_enc  = {obit, m_enc[1]};
        if (!m_prev_en) begin m_rise++; m_rise_last = m_cyc; end
        if (sof) begin m_sof++; m_sof_pos = m_en; m_open = 1'b1; end
        if (tail) m_tail++;
        if (eof) begin
          m_eof++; m_eof_pos = m_en; m_eof_tail = tail; m_eof_trunc = trunc; m_open = 1'b0;
        end
      end else if (m_open) begin
        m_gap++;
        if (!ready) m_gap_bad++;
      end
      m_prev_en = en;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic snap();
    en0 = m_en; hs0 = m_hs; sof0 = m_sof; eof0 = m_eof;
    rise0 = m_rise; gap0 = m_gap; gapb0 = m_gap_bad; tail0 = m_tail;
  endtask

  // Called just after a rising edge; returns just after the handshake edge.
  task automatic send_word(input logic [7:0] w);
    int n;
    n = 0;
    valid = 1'b1; data = w;
    @(negedge clk);
    while (!ready && n < 100) begin @(negedge clk); n++; end
    if (!ready) begin
      checks++; errors++;
      $display("FAIL send_word_timeout ready=%b required 1", ready);
    end
    tick();
    valid = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] f);
    for (int i = 3; i >= 0; i--) send_word(f[i*8 +: 8]);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!ready && n < 100) begin @(negedge clk); n++; end
    if (!ready) begin
      checks++; errors++;
      $display("FAIL wait_ready_timeout ready=%b required 1", ready);
    end
  endtask

  task automatic wait_eof(input int target);
    int n;
    n = 0;
    while (m_eof < target && n < 300) begin @(negedge clk); #1; n++; end
    if (m_eof < target) begin
      checks++; errors++;
      $display("FAIL wait_eof_timeout eofs=%0d required %0d", m_eof, target);
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #10;
    checks++;
    if ({ready, obit, en, sof, eof, tail, trunc} !== 7'b0) begin
      errors++; $display("FAIL reset_outputs got %b want 0000000", {ready, obit, en, sof, eof, tail, trunc});
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (ready !== 1'b1 || en !== 1'b0) begin
      errors++; $display("FAIL reset_ready got ready=%b en=%b want ready=1 en=0", ready, en);
    end
  endtask

  task automatic test_single_frame();
    int hs_first;
    snap();
    send_word(8'hA5);
    hs_first = m_hs_last;
    send_word(8'h3C); send_word(8'hFF); send_word(8'h00);
    wait_eof(eof0 + 1);
    checks++;
    if (m_bits[33:0] !== exp34) begin errors++; $display("FAIL single_bits got %h want %h", m_bits[33:0], exp34); end
    checks++;
    if (m_en - en0 !== 34) begin errors++; $display("FAIL single_en_cycles got %0d want 34", m_en - en0); end
    checks++;
    if (m_rise - rise0 !== 1) begin errors++; $display("FAIL single_contiguous got %0d bursts want 1", m_rise - rise0); end
    checks++;
    if (m_rise_last !== hs_first + 1) begin errors++; $display("FAIL single_latency got cycle %0d want %0d", m_rise_last, hs_first + 1); end
    checks++;
    if (m_sof - sof0 !== 1 || m_sof_pos - en0 !== 1) begin
      errors++; $display("FAIL single_sof got count %0d pos %0d want 1 1", m_sof - sof0, m_sof_pos - en0);
    end
    checks++;
    if (m_eof_pos - en0 !== 34 || m_eof_tail !== 1'b1 || m_eof_trunc !== 1'b0) begin
      errors++; $display("FAIL single_eof got pos %0d tail %b trunc %b want 34 1 0", m_eof_pos - en0, m_eof_tail, m_eof_trunc);
    end
    checks++;
    if (m_tail - tail0 !== 2) begin errors++; $display("FAIL single_tail_cycles got %0d want 2", m_tail - tail0); end
    checks++;
    if (m_enc !== 2'b00) begin errors++; $display("FAIL single_enc_state got %b want 00", m_enc); end
    checks++;
    if (m_hs - hs0 !== 4) begin errors++; $display("FAIL single_handshakes got %0d want 4", m_hs - hs0); end
    tick();
  endtask

  task automatic test_gap();
    snap();
    send_word(8'hA5); send_word(8'h3C);
    wait_ready();
    tick(); tick(); tick();
    send_word(8'hFF); send_word(8'h00);
    wait_eof(eof0 + 1);
    checks++;
    if (m_gap - gap0 !== 3 || m_gap_bad - gapb0 !== 0) begin
      errors++; $display("FAIL gap_cycles got %0d (not ready %0d) want 3 (0)", m_gap - gap0, m_gap_bad - gapb0);
    end
    checks++;
    if (m_bits[33:0] !== exp34 || m_en - en0 !== 34) begin
      errors++; $display("FAIL gap_bits got %h/%0d want %h/34", m_bits[33:0], m_en - en0, exp34);
    end
    checks++;
    if (m_enc !== 2'b00) begin errors++; $display("FAIL gap_enc_state got %b want 00", m_enc); end
    tick();
  endtask

  task automatic test_abort();
    snap();
    send_word(8'hA5); send_word(8'h3C);
    tick(); tick(); tick();
    abort = 1'b1; valid = 1'b1; data = 8'hEE;
    tick();
    abort = 1'b0; valid = 1'b0;
    wait_eof(eof0 + 1);
    @(negedge clk);
    checks++;
    if (en !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL abort_idle got en=%b ready=%b want 0 1", en, ready); end
    tick(); tick(); tick();
    checks++;
    if (m_bits[13:0] !== 14'b10100101_0011_00 || m_en - en0 !== 14) begin
      errors++; $display("FAIL abort_bits got %b/%0d want 10100101001100/14", m_bits[13:0], m_en - en0);
    end
    checks++;
    if (m_eof_trunc !== 1'b1 || m_eof_tail !== 1'b1 || m_tail - tail0 !== 2) begin
      errors++; $display("FAIL abort_eof got trunc %b tail %b tails %0d want 1 1 2", m_eof_trunc, m_eof_tail, m_tail - tail0);
    end
    checks++;
    if (m_hs - hs0 !== 2) begin errors++; $display("FAIL abort_handshakes got %0d want 2", m_hs - hs0); end
    // abort in WAIT together with an offered word
    snap();
    send_word(8'h11);
    wait_ready();
    tick();
    valid = 1'b1; data = 8'hEE; abort = 1'b1;
    tick();
    valid = 1'b0; abort = 1'b0;
    wait_eof(eof0 + 1);
    tick(); tick(); tick(); tick();
    checks++;
    if (m_bits[9:0] !== 10'b00010001_00 || m_en - en0 !== 10 || m_eof_trunc !== 1'b1) begin
      errors++; $display("FAIL abort_wait got %b/%0d trunc %b want 0001000100/10 trunc 1", m_bits[9:0], m_en - en0, m_eof_trunc);
    end
  endtask

  task automatic test_back_to_back();
    snap();
    send_frame(32'hA53CFF00);
    send_frame(32'h12345678);
    wait_eof(eof0 + 2);
    checks++;
    if (m_bits[67:0] !== exp68 || m_en - en0 !== 68) begin
      errors++; $display("FAIL b2b_bits got %h/%0d want %h/68", m_bits[67:0], m_en - en0, exp68);
    end
    checks++;
    if (m_rise - rise0 !== 1) begin errors++; $display("FAIL b2b_contiguous got %0d bursts want 1", m_rise - rise0); end
    checks++;
    if (m_sof - sof0 !== 2 || m_sof_pos - en0 !== 35) begin
      errors++; $display("FAIL b2b_sof got count %0d pos %0d want 2 35", m_sof - sof0, m_sof_pos - en0);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    send_word(8'hA5); send_word(8'h3C); send_word(8'hFF);
    tick(); tick();
    snap();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ready, obit, en, sof, eof, tail, trunc} !== 7'b0) begin
      errors++; $display("FAIL midreset_outputs got %b want 0000000", {ready, obit, en, sof, eof, tail, trunc});
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL midreset_ready got %b want 1", ready); end
    snap();
    send_frame(32'hA53CFF00);
    wait_eof(eof0 + 1);
    checks++;
    if (m_bits[33:0] !== exp34 || m_en - en0 !== 34 || m_sof_pos - en0 !== 1) begin
      errors++; $display("FAIL midreset_frame got %h/%0d sof %0d want %h/34 sof 1", m_bits[33:0], m_en - en0, m_sof_pos - en0, exp34);
    end
    checks++;
    if (m_eof - eof0 !== 1 || m_eof_trunc !== 1'b0 || m_enc !== 2'b00) begin
      errors++; $display("FAIL midreset_eof got eofs %0d trunc %b enc %b want 1 0 00", m_eof - eof0, m_eof_trunc, m_enc);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [7:0] w [8];
    int k, pos, n, bad;
    w = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78};
    k = 0; pos = 0; n = 0; bad = 0;
    snap();
    valid = 1'b1; data = w[0];
    while (k < 8 && n < 300) begin
      @(negedge clk); n++;
      if (en) begin
        pos = sof ? 0 : pos + 1;
        if (ready && !(pos == 7 || pos == 15 || pos == 23 || pos == 33)) bad++;
      end
      if (ready) k++;
      tick();
      if (k < 8) data = w[k]; else valid = 1'b0;
    end
    valid = 1'b0;
    wait_eof(eof0 + 2);
    checks++;
    if (k !== 8 || bad !== 0) begin errors++; $display("FAIL bp_ready_positions got words %0d bad %0d want 8 0", k, bad); end
    checks++;
    if (m_hs - hs0 !== 8) begin errors++; $display("FAIL bp_handshakes got %0d want 8", m_hs - hs0); end
    checks++;
    if (m_bits[67:0] !== exp68 || m_en - en0 !== 68 || m_rise - rise0 !== 1) begin
      errors++; $display("FAIL bp_bits got %h/%0d/%0d want %h/68/1", m_bits[67:0], m_en - en0, m_rise - rise0, exp68);
    end
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp34 = {8'hA5, 8'h3C, 8'hFF, 8'h00, 2'b00};
    exp68 = {exp34, 8'h12, 8'h34, 8'h56, 8'h78, 2'b00};
    test_reset();
    test_single_frame();
    test_gap();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_backpressure();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
